input_debouncer: RTL and testbench

//  Two-channel switch conditioner feeding the 2-input gate stage (a, b).
//  - Synchronises raw board switches into clk.
//  - Rejects contact bounce with a per-channel stability counter.
//  - Emits clean levels plus one-cycle edge pulses.

---
 rtl/input_debouncer.sv | 208 ++++++++++++++++++++
 tb/tb_input_debouncer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// ============================================================================
// input_debouncer
// ----------------------------------------------------------------------------
// Two-channel switch conditioner for the two-input gate stage (inputs a, b).
// Each channel:
//   - synchronises its raw board switch into clk with a two-flop chain,
//   - rejects contact bounce with an IDLE/CHECK FSM and a stability counter,
//   - presents a clean level plus registered one-cycle rise/fall pulses.
// The channels share only the clock and reset; busy is the OR of both
// channels' CHECK state.
//
// Parameters
//   STABLE_CYCLES  consecutive cycles the synchronised input must differ from
//                  the current output before the new level is accepted (>=1)
//
// Ports
//   clk     in   single clock, all state updates on the rising edge
//   rst_n   in   synchronous active-low reset
//   a_raw   in   raw switch a (asynchronous, may bounce)
//   b_raw   in   raw switch b (asynchronous, may bounce)
//   a_out   out  debounced level a
//   b_out   out  debounced level b
//   a_rise  out  one-cycle pulse on the edge a_out goes 0->1
//   a_fall  out  one-cycle pulse on the edge a_out goes 1->0
//   b_rise  out  one-cycle pulse on the edge b_out goes 0->1
//   b_fall  out  one-cycle pulse on the edge b_out goes 1->0
//   busy    out  high while either channel is in CHECK
// ============================================================================

// ----------------------------------------------------------------------------
// debounce_channel
// ----------------------------------------------------------------------------
// One independent channel: synchroniser, IDLE/CHECK FSM, stability counter,
// level and edge-pulse registers.
//
// Ports
//   clk, rst_n  as for the top level
//   raw         raw asynchronous switch input
//   level       debounced level
//   rise, fall  registered one-cycle edge pulses
//   busy        combinational, high while the FSM is in CHECK
// ----------------------------------------------------------------------------
module debounce_channel #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    // Counter value at which the final differing cycle is being observed.
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

    // With a single required cycle the first difference is already enough,
    // so the channel toggles straight from IDLE and never enters CHECK.
    localparam bit DIRECT_TOGGLE = (STABLE_CYCLES == 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CHECK = 1'b1
    } state_t;

    logic             sync_s1;
    logic             sync_s2;
    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] next_cnt;
    logic             next_level;
    logic             next_rise;
    logic             next_fall;
    logic             differs;

    // Only the second synchroniser stage is ever looked at downstream.
    assign differs = (sync_s2 != level);

    // State, counter, synchroniser and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_s1 <= 1'b0;
            sync_s2 <= 1'b0;
            state   <= IDLE;
            cnt     <= CNT_ZERO;
            level   <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            sync_s1 <= raw;
            sync_s2 <= sync_s1;
            state   <= next_state;
            cnt     <= next_cnt;
            level   <= next_level;
            rise    <= next_rise;
            fall    <= next_fall;
        end
    end

    // Next-state logic. Pulses default low so they last exactly one cycle;
    // a toggle sets the matching pulse in the same edge that flips the level,
    // and since only one direction is possible per toggle, rise and fall are
    // mutually exclusive.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        next_level = level;
        next_rise  = 1'b0;
        next_fall  = 1'b0;

        case (state)
            IDLE: begin
                next_cnt = CNT_ZERO;
                if (differs) begin
                    if (DIRECT_TOGGLE) begin
                        next_level = ~level;
                        next_rise  = ~level;
                        next_fall  = level;
                    end else begin
                        next_state = CHECK;
                        next_cnt   = CNT_ONE;
                    end
                end
            end

            CHECK: begin
                if (!differs) begin
                    // Bounce: input went back before acceptance, so the
                    // count is thrown away and the next difference restarts it.
                    next_state = IDLE;
                    next_cnt   = CNT_ZERO;
                end else if (cnt == CNT_LAST) begin
                    next_state = IDLE;
                    next_cnt   = CNT_ZERO;
                    next_level = ~level;
                    next_rise  = ~level;
                    next_fall  = level;
                end else begin
                    next_cnt = cnt + CNT_ONE;
                end
            end

            default: begin
                next_state = IDLE;
                next_cnt   = CNT_ZERO;
            end
        endcase
    end

    assign busy = (state == CHECK);

endmodule

// ----------------------------------------------------------------------------
// input_debouncer (top)
// ----------------------------------------------------------------------------
module input_debouncer #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a_raw,
    input  logic b_raw,
    output logic a_out,
    output logic b_out,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall,
    output logic busy
);

    logic a_busy;
    logic b_busy;

    debounce_channel #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_chan_a (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (a_raw),
        .level (a_out),
        .rise  (a_rise),
        .fall  (a_fall),
        .busy  (a_busy)
    );

    debounce_channel #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_chan_b (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (b_raw),
        .level (b_out),
        .rise  (b_rise),
        .fall  (b_fall),
        .busy  (b_busy)
    );

    assign busy = a_busy | b_busy;

endmodule

// File: tb/tb_input_debouncer.sv
// ============================================================================
// tb_input_debouncer
// ----------------------------------------------------------------------------
// Directed testbench for input_debouncer with STABLE_CYCLES = 4.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, so "tick k" below means "just after the k-th edge since the
// stimulus change". With the default setting a clean change is accepted on
// tick 6 and busy is high on ticks 3..5.
// Observation vector bit order: a_out, b_out, a_rise, a_fall, b_rise, b_fall, busy
// ============================================================================
module tb_input_debouncer;

    logic clk;
    logic rst_n;
    logic a_raw;
    logic b_raw;
    logic a_out;
    logic b_out;
    logic a_rise;
    logic a_fall;
    logic b_rise;
    logic b_fall;
    logic busy;

    wire [6:0] obs = {a_out, b_out, a_rise, a_fall, b_rise, b_fall, busy};

    int checks;
    int errors;

    input_debouncer #(
        .STABLE_CYCLES(4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a_raw  (a_raw),
        .b_raw  (b_raw),
        .a_out  (a_out),
        .b_out  (b_out),
        .a_rise (a_rise),
        .a_fall (a_fall),
        .b_rise (b_rise),
        .b_fall (b_fall),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset held with both raw inputs high: everything stays 0.
    task automatic test_reset();
        rst_n = 1'b0;
        a_raw = 1'b1;
        b_raw = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (obs !== 7'b0000000) begin
                errors++;
                $display("[TB] FAIL reset tick%0d: got %b expected %b", i, obs, 7'b0000000);
            end
        end
    endtask

    // Raw inputs high through reset: both rise after full latency on release.
    task automatic test_hold_through_reset();
        logic [6:0] exp;
        rst_n = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i == 6)      exp = 7'b1110100;
            else if (i == 7) exp = 7'b1100000;
            else             exp = {6'b000000, (i >= 3 && i <= 5)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL hold_through_reset tick%0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    // Channel a falls while b holds 1, then channel b falls.
    task automatic test_fall();
        logic [6:0] exp;
        a_raw = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i == 6)      exp = 7'b0101000;
            else if (i == 7) exp = 7'b0100000;
            else             exp = {6'b110000, (i >= 3 && i <= 5)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL fall_a tick%0d: got %b expected %b", i, obs, exp);
            end
        end
        b_raw = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i == 6)      exp = 7'b0000010;
            else if (i == 7) exp = 7'b0000000;
            else             exp = {6'b010000, (i >= 3 && i <= 5)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL fall_b tick%0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    // Clean 0->1 on a: accepted on tick 6, one-cycle rise pulse.
    task automatic test_clean_rise();
        logic [6:0] exp;
        a_raw = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i == 6)      exp = 7'b1010000;
            else if (i == 7) exp = 7'b1000000;
            else             exp = {6'b000000, (i >= 3 && i <= 5)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL clean_rise tick%0d: got %b expected %b", i, obs, exp);
            end
        end
        a_raw = 1'b0;
        repeat (8) tick();
        checks++;
        if (obs !== 7'b0000000) begin
            errors++;
            $display("[TB] FAIL clean_rise_return: got %b expected %b", obs, 7'b0000000);
        end
    endtask

    // Revert one cycle short of acceptance, then per-cycle bounce, then hold.
    task automatic test_bounce();
        logic [3:0] pattern;
        a_raw = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            tick();
            if (i == 3) a_raw = 1'b0;
            checks++;
            if ({a_out, a_rise} !== 2'b00) begin
                errors++;
                $display("[TB] FAIL revert tick%0d: a_out,a_rise got %b expected %b", i, {a_out, a_rise}, 2'b00);
            end
        end
        pattern = 4'b1010;
        for (int i = 3; i >= 0; i--) begin
            a_raw = pattern[i];
            tick();
            checks++;
            if ({a_out, a_rise} !== 2'b00) begin
                errors++;
                $display("[TB] FAIL bounce step%0d: a_out,a_rise got %b expected %b", 3 - i, {a_out, a_rise}, 2'b00);
            end
        end
        a_raw = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            checks++;
            if ({a_out, a_rise} !== ((i == 6) ? 2'b11 : 2'b00)) begin
                errors++;
                $display("[TB] FAIL bounce_hold tick%0d: a_out,a_rise got %b expected %b", i, {a_out, a_rise}, ((i == 6) ? 2'b11 : 2'b00));
            end
        end
        a_raw = 1'b0;
        repeat (8) tick();
        checks++;
        if (a_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bounce_return: a_out got %b expected %b", a_out, 1'b0);
        end
    endtask

    // Both channels change together, up and then down.
    task automatic test_back_to_back();
        logic [6:0] exp;
        a_raw = 1'b1;
        b_raw = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i == 6)      exp = 7'b1110100;
            else if (i == 7) exp = 7'b1100000;
            else             exp = {6'b000000, (i >= 3 && i <= 5)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL both_rise tick%0d: got %b expected %b", i, obs, exp);
            end
        end
        a_raw = 1'b0;
        b_raw = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i == 6)      exp = 7'b0001010;
            else if (i == 7) exp = 7'b0000000;
            else             exp = {6'b110000, (i >= 3 && i <= 5)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL both_fall tick%0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    // Reset on the 4th edge while a is in CHECK: count discarded, no pulse.
    task automatic test_reset_mid_check();
        a_raw = 1'b1;
        repeat (3) tick();
        checks++;
        if (obs !== 7'b0000001) begin
            errors++;
            $display("[TB] FAIL mid_check_busy: got %b expected %b", obs, 7'b0000001);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (obs !== 7'b0000000) begin
            errors++;
            $display("[TB] FAIL mid_check_reset_edge: got %b expected %b", obs, 7'b0000000);
        end
        rst_n = 1'b1;
        a_raw = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            checks++;
            if (obs !== 7'b0000000) begin
                errors++;
                $display("[TB] FAIL mid_check_after tick%0d: got %b expected %b", i, obs, 7'b0000000);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        a_raw  = 1'b0;
        b_raw  = 1'b0;
        test_reset();
        test_hold_through_reset();
        test_fall();
        test_clean_rise();
        test_bounce();
        test_back_to_back();
        test_reset_mid_check();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
